nibble_serial_adder_ctrl: RTL and testbench

//  Sequencer that time-shares one 4-bit carry-lookahead slice to add WIDTH-bit operands, one nibble per cycle.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 18 +
 rtl/nibble_serial_adder_ctrl_cla4_slice.sv | 30 +++
 rtl/nibble_serial_adder_ctrl.sv | 111 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// State encoding, slice width and index-width derivation used by the top and its bench.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned SliceBits = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Keeps the index at least one bit wide when only one slice exists.
  function automatic int unsigned idx_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice shared by the serial adder.
// Exposes the carry into bit 3 so the caller can derive signed overflow.
module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c3_o,
  output logic       c4_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i | b_i;
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_i);
    s_o  = a_i ^ b_i ^ c[3:0];
    c3_o = c[3];
    c4_o = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle through a single shared CLA slice.
// Operands enter and results leave over valid/ready handshakes.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = SliceBits
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW = idx_width(NSLICE);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  state_e          state_q;
  logic [WIDTH-1:0] opa_q, opb_q, f_q;
  logic            carry_q, cout_q, ovf_q;
  logic [IdxW-1:0] idx_q;
  logic            in_ready_q, out_valid_q, busy_q;

  logic [SLICE-1:0] slice_a, slice_b, slice_s;
  logic             slice_c3, slice_c4;

  always_comb begin
    slice_a = opa_q[idx_q*SLICE +: SLICE];
    slice_b = opb_q[idx_q*SLICE +: SLICE];
  end

  cla4_slice u_cla4_slice (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .c_i  (carry_q),
    .s_o  (slice_s),
    .c3_o (slice_c3),
    .c4_o (slice_c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      f_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            opa_q      <= A;
            opb_q      <= B;
            carry_q    <= Cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          f_q[idx_q*SLICE +: SLICE] <= slice_s;
          carry_q                   <= slice_c4;
          if (idx_q == LastIdx) begin
            // Top slice: its bit 3 is the operand MSB, so C3^C4 is signed overflow.
            cout_q      <= slice_c4;
            ovf_q       <= slice_c3 ^ slice_c4;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign F         = f_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed vectors, corner sequences
// and randomized back-to-back traffic against an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int NOPS = 1000;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, F;
  logic         Cin, Cout, Ovf, busy;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] f;
    logic         cout, ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] f;
    logic         cout, ovf;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer addition.
  function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
    exp_t r;
    int unsigned u;
    int s;
    u = int'(a) + int'(b) + int'(cin);
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    r.f    = u[W-1:0];
    r.cout = (u > 32'hFFFF);
    r.ovf  = (s > 32767) || (s < -32768);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    A = a; B = b; Cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  vec_t vecs[9];
  exp_t q[$];

  initial begin
    int lat, sent, recv, cyc;
    exp_t e, got;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_F", F, 0);
    check("rst_Cout", Cout, 0);
    check("rst_Ovf", Ovf, 0);
    check("rst_busy", busy, 0);

    // Directed vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      check("run_busy", busy, 1);
      check("run_in_ready", in_ready, 0);
      wait_out(lat);
      check("latency", lat, 5);
      check("vec_F", F, vecs[i].f);
      check("vec_Cout", Cout, vecs[i].cout);
      check("vec_Ovf", Ovf, vecs[i].ovf);
      finish_op();
    end

    // Back-pressure in DONE with ignored in_valid pulses
    start_op(16'hABCD, 16'h1111, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_F", F, 16'hBCDE);
      check("hold_in_ready", in_ready, 0);
      in_valid = 1'(i & 1);
      A = W'($urandom); B = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish_op();
    check("hold_busy_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("no_queued_op", busy, 0);

    // Reset in the second RUN cycle
    start_op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", out_valid, 0);
    check("midrun_F", F, 0);
    check("midrun_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_out(lat);
    check("post_rst_F", F, 16'h0002);
    check("post_rst_Cout", Cout, 0);
    finish_op();

    // Randomized back-to-back traffic, in_valid held high, operands scrambled after handshake
    sent = 0; recv = 0; cyc = 0;
    while (recv < NOPS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(3) != 0);
      if (out_valid && out_ready) begin
        e = q.pop_front();
        got.f = F; got.cout = Cout; got.ovf = Ovf;
        check("rnd_F", got.f, e.f);
        check("rnd_Cout", got.cout, e.cout);
        check("rnd_Ovf", got.ovf, e.ovf);
        recv++;
      end
      if (in_ready && sent < NOPS) begin
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        if ($urandom_range(7) == 0) ra = 16'hFFFF;
        if ($urandom_range(7) == 0) rb = 16'h8000;
        A = ra; B = rb; Cin = rc; in_valid = 1'b1;
        q.push_back(ref_add(ra, rb, rc));
        sent++;
      end else begin
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        in_valid = (sent < NOPS);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rnd_received", recv, NOPS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
